// File: rtl/mp_ram_loader.sv
// Framed byte-stream loader for the matching pursuit PE RAMs: decodes a command byte,
// streams signal/dictionary bytes into their RAM write ports, clears x, and pulses start.
module mp_ram_loader #(
  parameter int SIGNAL_ADDR_WIDTH         = 4,
  parameter int DICTIONARY_ADDR_WIDTH     = 8,
  parameter int REPRESENTATION_ADDR_WIDTH = 4
) (
  input  logic                                 clock,
  input  logic                                 resetN,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [7:0]                           in_data,
  input  logic                                 in_last,
  output logic                                 y_we,
  output logic [SIGNAL_ADDR_WIDTH-1:0]         y_addr,
  output logic [7:0]                           y_wdata,
  output logic                                 dict_we,
  output logic [DICTIONARY_ADDR_WIDTH-1:0]     dict_addr,
  output logic [7:0]                           dict_wdata,
  output logic                                 x_we,
  output logic [REPRESENTATION_ADDR_WIDTH-1:0] x_addr,
  output logic [7:0]                           x_wdata,
  output logic                                 mp_start,
  output logic [SIGNAL_ADDR_WIDTH:0]           y_count,
  output logic [DICTIONARY_ADDR_WIDTH:0]       dict_count,
  output logic                                 error,
  output logic                                 busy
);
  localparam int SW = SIGNAL_ADDR_WIDTH;
  localparam int DW = DICTIONARY_ADDR_WIDTH;
  localparam int CW = ((SW > DW) ? SW : DW) + 1;

  typedef enum logic [2:0] {IDLE, LOAD_Y, LOAD_D, CLEAR_X, START, DRAIN} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          w_fire;
  logic          w_room;
  logic [CW-1:0] w_lim;
  logic [CW-1:0] w_next;

  // Ready depends on state only, so there is no path from in_valid back to in_ready.
  assign in_ready = (r_state != CLEAR_X) && (r_state != START);
  assign busy     = (r_state != IDLE);
  assign x_wdata  = '0;
  assign w_fire   = in_valid && in_ready;

  always_comb begin
    w_lim  = (r_state == LOAD_D) ? (CW'(1) << DW) : (CW'(1) << SW);
    w_room = (r_cnt < w_lim);
    w_next = r_cnt + {{(CW-1){1'b0}}, w_room};
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      y_we       <= 1'b0;
      y_addr     <= '0;
      y_wdata    <= '0;
      dict_we    <= 1'b0;
      dict_addr  <= '0;
      dict_wdata <= '0;
      x_we       <= 1'b0;
      x_addr     <= '0;
      mp_start   <= 1'b0;
      y_count    <= '0;
      dict_count <= '0;
      error      <= 1'b0;
    end else begin
      y_we     <= 1'b0;
      dict_we  <= 1'b0;
      mp_start <= 1'b0;
      case (r_state)
        IDLE: if (w_fire) begin
          case (in_data[1:0])
            2'd0: if (in_last) y_count <= '0;
                  else begin r_state <= LOAD_Y; r_cnt <= '0; end
            2'd1: if (in_last) dict_count <= '0;
                  else begin r_state <= LOAD_D; r_cnt <= '0; end
            2'd2: if (in_last) begin
                    r_state <= CLEAR_X;
                    x_we    <= 1'b1;
                    x_addr  <= '0;
                  end else begin
                    r_state <= DRAIN;
                    error   <= 1'b1;
                  end
            default: if (in_last) begin
                    r_state  <= START;
                    mp_start <= 1'b1;
                  end else begin
                    r_state <= DRAIN;
                    error   <= 1'b1;
                  end
          endcase
        end
        LOAD_Y: if (w_fire) begin
          if (w_room) begin
            y_we    <= 1'b1;
            y_addr  <= r_cnt[SW-1:0];
            y_wdata <= in_data;
            r_cnt   <= w_next;
          end else error <= 1'b1;
          if (in_last) begin
            y_count <= w_next[SW:0];
            r_state <= IDLE;
          end
        end
        LOAD_D: if (w_fire) begin
          if (w_room) begin
            dict_we    <= 1'b1;
            dict_addr  <= r_cnt[DW-1:0];
            dict_wdata <= in_data;
            r_cnt      <= w_next;
          end else error <= 1'b1;
          if (in_last) begin
            dict_count <= w_next[DW:0];
            r_state    <= IDLE;
          end
        end
        CLEAR_X: if (x_addr == '1) begin
          x_we    <= 1'b0;
          r_state <= IDLE;
        end else x_addr <= x_addr + 1'b1;
        START: r_state <= IDLE;
        DRAIN: if (w_fire && in_last) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
